// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, oversample ratio
// and the baud divider computation.
package uart_pkg;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status pulses out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  modport master (output rx, input d_out, rx_done, frame_err, parity_err);
  modport slave  (input rx, output d_out, rx_done, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_baud_gen.sv
// Free-running oversample tick: one clk-wide pulse every DIV clocks.
module baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)           cnt <= '0;
    else if (cnt == TOP) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TOP);
endmodule

// File: rtl/uart_rx.sv
// UART receiver, DBIT-N-1 by default; define UART_RX_PARITY_EN to expect
// one even-parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int DBIT   = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [3:0] MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BLAST = 3'(DBIT - 1);

  logic [1:0] sync;
  logic       rx_s, tick;
  state_t     state, state_n;
  logic [3:0] tcnt, tcnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] sh, sh_n, dout, dout_n;
  logic       par, par_n;
  logic       done_q, done_n, ferr_q, ferr_n, perr_q, perr_n;

  // Synchronizer idles high so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], bus.rx};
  end
  assign rx_s = sync[1];

  baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    sh_n    = sh;
    par_n   = par;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    case (state)
      ST_IDLE: if (!rx_s) begin
        state_n = ST_START;
        tcnt_n  = '0;
      end
      ST_START: if (tick) begin
        if (tcnt == MID) begin
          tcnt_n  = '0;
          bcnt_n  = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_DATA: if (tick) begin
        if (tcnt == LAST) begin
          tcnt_n     = '0;
          sh_n[bcnt] = rx_s;
          if (bcnt == BLAST) state_n = PAR_EN ? ST_PARITY : ST_STOP;
          else               bcnt_n  = bcnt + 3'd1;
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_PARITY: if (tick) begin
        if (tcnt == LAST) begin
          tcnt_n  = '0;
          par_n   = rx_s;
          state_n = ST_STOP;
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_STOP: if (tick) begin
        if (tcnt == LAST) begin
          tcnt_n = '0;
          // Framing error wins over parity so only one pulse fires per frame.
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
          end else if (PAR_EN && ((^sh[DBIT-1:0]) != par)) begin
            perr_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            dout_n  = sh;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end else tcnt_n = tcnt + 4'd1;
      end
      ST_BREAK: if (rx_s) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      sh     <= '0;
      par    <= 1'b0;
      dout   <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      bcnt   <= bcnt_n;
      sh     <= sh_n;
      par    <= par_n;
      dout   <= dout_n;
      done_q <= done_n;
      ferr_q <= ferr_n;
      perr_q <= perr_n;
    end
  end

  assign bus.d_out      = dout;
  assign bus.rx_done    = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = PAR_EN & perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectation queue checked every clk.
module tb_uart_rx;
  localparam int CLK_HZ  = 3_200_000;
  localparam int BAUD    = 100_000;
  localparam int CPB     = CLK_HZ / BAUD;  // 32 clk per bit
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int         kind;  // 0 done, 1 frame_err, 2 parity_err
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  uart_rx_if bus();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DBIT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  int         n_done = 0, n_ferr = 0, n_perr = 0;
  bit         armed = 1'b0;
  exp_t       exp_q[$];
  logic [7:0] exp_dout = 8'h00;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference checker: pulses must match queued frame outcomes in order,
  // d_out must always equal the last good byte (0 after reset).
  initial forever begin
    @(posedge clk);
    #1;
    if (armed) begin
      if (reset) begin
        exp_q.delete();
        exp_dout = 8'h00;
      end else if (bus.rx_done || bus.frame_err || bus.parity_err) begin
        int got_kind;
        got_kind = bus.rx_done ? 0 : (bus.frame_err ? 1 : 2);
        chk("pulse_onehot", $countones({bus.rx_done, bus.frame_err, bus.parity_err}), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", got_kind, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", got_kind, e.kind);
          if (e.kind == 0) exp_dout = e.data;
        end
        if (bus.rx_done)    n_done++;
        if (bus.frame_err)  n_ferr++;
        if (bus.parity_err) n_perr++;
      end
      chk("d_out", int'(bus.d_out), int'(exp_dout));
    end
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit par_flip);
    exp_t e;
    e.data = data;
    e.kind = !stop ? 1 : ((PAR_EN && par_flip) ? 2 : 0);
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (PAR_EN) send_bit((^data) ^ par_flip);
    send_bit(stop);
    chk("frame_outcome_seen", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b55;
    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    @(negedge clk);
    chk("reset_dout", int'(bus.d_out), 0);
    chk("reset_pulses", int'({bus.rx_done, bus.frame_err, bus.parity_err}), 0);
    reset = 1'b0;
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(40);
    chk("a5_dout", int'(bus.d_out), 'hA5);
    chk("a5_done_cnt", n_done, 1);

    // 10-clk low glitch must be rejected at mid start bit
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    idle(80);
    chk("glitch_done_cnt", n_done + n_ferr + n_perr, 1);
    chk("glitch_dout", int'(bus.d_out), 'hA5);

    // Stop bit low, then line held low: exactly one frame_err
    send_frame(8'h3C, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(64);
    chk("brk_ferr_cnt", n_ferr, 1);
    chk("brk_done_cnt", n_done, 1);
    chk("brk_dout", int'(bus.d_out), 'hA5);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0);
    chk("b2b_first", int'(bus.d_out), 'h00);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(40);
    chk("b2b_second", int'(bus.d_out), 'hFF);
    chk("b2b_done_cnt", n_done, 3);

    // Reset in the middle of data bit 4 of 0x55
    b55 = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b55[i]);
    bus.rx = b55[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(400);
    chk("rst_done_cnt", n_done, 3);
    chk("rst_dout", int'(bus.d_out), 0);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(40);
    chk("post_rst_dout", int'(bus.d_out), 'h12);
    chk("post_rst_done_cnt", n_done, 4);

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1);
      idle(40);
      chk("par_bad_perr", n_perr, 1);
      chk("par_bad_dout", int'(bus.d_out), 'h12);
      send_frame(8'h07, 1'b1, 1'b0);
      idle(40);
      chk("par_good_dout", int'(bus.d_out), 'h07);
      chk("par_good_done", n_done, 5);
    end else begin
      chk("no_parity_pulses", n_perr, 0);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
